div_arbiter: RTL and testbench

//   Shares one iterative divider between REQUESTERS per-frame parameter updaters (delay rate, reverb size, filter

---
 rtl/div_arbiter.sv | 119 +++++++++++
 tb/tb_div_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sharing of one iterative divider among one-deep request slots,
// with a zero-divisor bypass and a WAIT timeout that forces an error response.
module div_arbiter #(
    parameter int REQUESTERS  = 4,
    parameter int WIDTH       = 32,
    parameter int DIV_TIMEOUT = 63
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [REQUESTERS-1:0]                req_valid,
    output logic [REQUESTERS-1:0]                req_ready,
    input  logic [REQUESTERS-1:0][WIDTH-1:0]     req_dividend,
    input  logic [REQUESTERS-1:0][WIDTH-1:0]     req_divisor,
    output logic [REQUESTERS-1:0]                resp_valid,
    output logic [WIDTH-1:0]                     resp_quotient,
    output logic [WIDTH-1:0]                     resp_remainder,
    output logic                                 resp_error,
    output logic [WIDTH-1:0]                     div_dividend,
    output logic [WIDTH-1:0]                     div_divisor,
    output logic                                 div_in_valid,
    input  logic [WIDTH-1:0]                     div_quotient,
    input  logic [WIDTH-1:0]                     div_remainder,
    input  logic                                 div_out_valid,
    input  logic                                 div_busy
);
    localparam int IW = $clog2(REQUESTERS);
    localparam int CW = $clog2(DIV_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                            r_state, w_next;
    logic [REQUESTERS-1:0]             r_pending;
    logic [REQUESTERS-1:0][WIDTH-1:0]  r_dividend, r_divisor;
    logic [IW-1:0]                     r_rr_ptr, r_grant, w_pick;
    logic [CW-1:0]                     r_cnt;
    logic                              w_found, w_zero, w_timeout;

    // Descending scan so the slot closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        for (int k = REQUESTERS - 1; k >= 0; k--) begin
            if (r_pending[(int'(r_rr_ptr) + k) % REQUESTERS]) begin
                w_pick  = IW'((int'(r_rr_ptr) + k) % REQUESTERS);
                w_found = 1'b1;
            end
        end
    end

    assign w_zero       = r_divisor[w_pick] == '0;
    assign w_timeout    = r_cnt == CW'(DIV_TIMEOUT);
    assign req_ready    = ~r_pending;
    assign div_in_valid = (r_state == ISSUE) && !div_busy;
    assign resp_valid   = (r_state == RESP) ? {{(REQUESTERS-1){1'b0}}, 1'b1} << r_grant : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  w_next = w_found ? (w_zero ? RESP : ISSUE) : IDLE;
            ISSUE: w_next = div_busy ? ISSUE : WAIT;
            WAIT:  w_next = (div_out_valid || w_timeout) ? RESP : WAIT;
            RESP:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending      <= '0;
            r_dividend     <= '0;
            r_divisor      <= '0;
            r_rr_ptr       <= '0;
            r_grant        <= '0;
            r_cnt          <= '0;
            resp_quotient  <= '0;
            resp_remainder <= '0;
            resp_error     <= 1'b0;
            div_dividend   <= '0;
            div_divisor    <= '0;
        end else begin
            for (int i = 0; i < REQUESTERS; i++) begin
                if (r_state == RESP && r_grant == IW'(i)) begin
                    r_pending[i] <= 1'b0;
                end else if (req_valid[i] && !r_pending[i]) begin
                    r_pending[i]  <= 1'b1;
                    r_dividend[i] <= req_dividend[i];
                    r_divisor[i]  <= req_divisor[i];
                end
            end
            r_cnt <= (r_state == WAIT) ? r_cnt + 1'b1 : '0;
            if (r_state == IDLE && w_found) begin
                r_grant  <= w_pick;
                r_rr_ptr <= IW'((int'(w_pick) + 1) % REQUESTERS);
                if (w_zero) begin
                    resp_quotient  <= '1;
                    resp_remainder <= r_dividend[w_pick];
                    resp_error     <= 1'b0;
                end else begin
                    div_dividend <= r_dividend[w_pick];
                    div_divisor  <= r_divisor[w_pick];
                end
            end
            if (r_state == WAIT && div_out_valid) begin
                resp_quotient  <= div_quotient;
                resp_remainder <= div_remainder;
                resp_error     <= 1'b0;
            end else if (r_state == WAIT && w_timeout) begin
                resp_quotient  <= '0;
                resp_remainder <= '0;
                resp_error     <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed checks of arbitration order, zero-divisor bypass, busy stall, timeout and reset.
module tb_div_arbiter;
    localparam int N = 4;
    localparam int W = 32;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N-1:0]         req_valid = '0;
    logic [N-1:0]         req_ready;
    logic [N-1:0][W-1:0]  req_dividend = '0;
    logic [N-1:0][W-1:0]  req_divisor = '0;
    logic [N-1:0]         resp_valid;
    logic [W-1:0]         resp_quotient, resp_remainder;
    logic                 resp_error;
    logic [W-1:0]         div_dividend, div_divisor;
    logic                 div_in_valid;
    logic [W-1:0]         div_quotient = '0;
    logic [W-1:0]         div_remainder = '0;
    logic                 div_out_valid;
    logic                 div_busy = 1'b0;

    int   checks = 0;
    int   errors = 0;
    int   lat = 34;
    int   cd = 0;
    int   starts = 0;
    logic model_on = 1'b1;
    logic force_ov = 1'b0;
    logic r_ov = 1'b0;

    div_arbiter #(.REQUESTERS(N), .WIDTH(W), .DIV_TIMEOUT(63)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .resp_valid(resp_valid), .resp_quotient(resp_quotient),
        .resp_remainder(resp_remainder), .resp_error(resp_error),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_in_valid(div_in_valid), .div_quotient(div_quotient),
        .div_remainder(div_remainder), .div_out_valid(div_out_valid),
        .div_busy(div_busy)
    );

    always #5 clk = ~clk;

    assign div_out_valid = r_ov | force_ov;

    // Divider stand-in: latches operands on a start, strobes the result lat cycles later.
    always @(posedge clk) begin
        if (div_in_valid) begin
            starts++;
            cd = lat;
            div_quotient  = div_dividend / div_divisor;
            div_remainder = div_dividend % div_divisor;
        end else if (cd > 0) begin
            cd--;
        end
    end

    always @(negedge clk) r_ov = model_on && cd == 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic req(input int s, input logic [31:0] dd, input logic [31:0] dv);
        req_valid[s]    = 1'b1;
        req_dividend[s] = dd;
        req_divisor[s]  = dv;
    endtask

    task automatic step;
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic wait_resp(input string tag, input int max, output logic [N-1:0] v,
                             output logic [31:0] q, output logic [31:0] r, output logic e);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (resp_valid == '0 && n < max);
        v = resp_valid;
        q = resp_quotient;
        r = resp_remainder;
        e = resp_error;
        if (resp_valid == '0) chk({tag, "_timeout"}, 32'(n), 32'(max + 1));
    endtask

    logic [N-1:0] v, seen;
    logic [31:0]  q, r;
    logic         e;
    int           s0;

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_div_in_valid", 32'(div_in_valid), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'hF);
        chk("rst_quot", resp_quotient, 32'h0);
        chk("rst_dividend", div_dividend, 32'h0);

        req(0, 4095, 16);
        step();
        chk("single_ready0", 32'(req_ready[0]), 32'h0);
        wait_resp("single", 100, v, q, r, e);
        chk("single_v", 32'(v), 32'h1);
        chk("single_q", q, 32'd255);
        chk("single_r", r, 32'd15);
        chk("single_e", 32'(e), 32'h0);
        chk("single_ready_resp", 32'(req_ready[0]), 32'h0);
        chk("single_starts", 32'(starts), 32'd1);
        @(negedge clk);
        chk("single_ready_after", 32'(req_ready), 32'hF);
        chk("single_v_drop", 32'(resp_valid), 32'h0);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        lat = 5;
        req(0, 100, 7);
        req(1, 200, 9);
        req(2, 300, 11);
        req(3, 400, 13);
        step();
        wait_resp("all0", 50, v, q, r, e);
        chk("all0_v", 32'(v), 32'h1);
        chk("all0_q", q, 32'd14);
        wait_resp("all1", 50, v, q, r, e);
        chk("all1_v", 32'(v), 32'h2);
        chk("all1_q", q, 32'd22);
        wait_resp("all2", 50, v, q, r, e);
        chk("all2_v", 32'(v), 32'h4);
        chk("all2_r", r, 32'd3);
        wait_resp("all3", 50, v, q, r, e);
        chk("all3_v", 32'(v), 32'h8);
        chk("all3_r", r, 32'd10);
        @(negedge clk);
        req(3, 70, 8);
        req(1, 90, 4);
        step();
        wait_resp("pair1", 50, v, q, r, e);
        chk("pair1_v", 32'(v), 32'h2);
        chk("pair1_q", q, 32'd22);
        wait_resp("pair3", 50, v, q, r, e);
        chk("pair3_v", 32'(v), 32'h8);
        chk("pair3_q", q, 32'd8);

        @(negedge clk);
        req(0, 10, 3);
        req(2, 20, 6);
        step();
        wait_resp("fair0", 50, v, q, r, e);
        chk("fair0_v", 32'(v), 32'h1);
        @(negedge clk);
        req(0, 11, 3);
        step();
        wait_resp("fair2", 50, v, q, r, e);
        chk("fair2_v", 32'(v), 32'h4);
        chk("fair2_q", q, 32'd3);
        wait_resp("fair0b", 50, v, q, r, e);
        chk("fair0b_v", 32'(v), 32'h1);
        chk("fair0b_r", r, 32'd2);

        @(negedge clk);
        s0 = starts;
        req(1, 32'h1234, 0);
        step();
        chk("zero_t1", 32'(resp_valid), 32'h0);
        @(negedge clk);
        chk("zero_v", 32'(resp_valid), 32'h2);
        chk("zero_q", resp_quotient, 32'hFFFF_FFFF);
        chk("zero_r", resp_remainder, 32'h1234);
        chk("zero_e", 32'(resp_error), 32'h0);
        chk("zero_starts", 32'(starts), 32'(s0));

        @(negedge clk);
        div_busy = 1'b1;
        model_on = 1'b0;
        s0 = starts;
        req(3, 50, 5);
        step();
        repeat (10) @(negedge clk);
        chk("busy_no_start", 32'(starts), 32'(s0));
        chk("busy_in_valid", 32'(div_in_valid), 32'h0);
        chk("busy_dividend", div_dividend, 32'd50);
        div_busy = 1'b0;
        #1;
        chk("busy_release", 32'(div_in_valid), 32'h1);
        @(negedge clk);
        chk("busy_once", 32'(starts), 32'(s0 + 1));
        chk("busy_pulse_end", 32'(div_in_valid), 32'h0);
        wait_resp("tmo", 200, v, q, r, e);
        chk("tmo_v", 32'(v), 32'h8);
        chk("tmo_e", 32'(e), 32'h1);
        chk("tmo_q", q, 32'h0);
        @(negedge clk);
        force_ov = 1'b1;
        @(negedge clk);
        force_ov = 1'b0;
        seen = '0;
        repeat (5) begin
            @(negedge clk);
            seen |= resp_valid;
        end
        chk("stray_ignored", 32'(seen), 32'h0);
        chk("stray_err_hold", 32'(resp_error), 32'h1);

        model_on = 1'b1;
        lat = 20;
        s0 = starts;
        req(0, 9, 3);
        step();
        for (int i = 0; i < 20 && starts == s0; i++) @(negedge clk);
        chk("rstw_started", 32'(starts), 32'(s0 + 1));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstw_resp_valid", 32'(resp_valid), 32'h0);
        chk("rstw_ready", 32'(req_ready), 32'hF);
        chk("rstw_err", 32'(resp_error), 32'h0);
        chk("rstw_dividend", div_dividend, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        seen = '0;
        repeat (30) begin
            @(negedge clk);
            seen |= resp_valid;
        end
        chk("rstw_late_ignored", 32'(seen), 32'h0);
        chk("rstw_no_restart", 32'(starts), 32'(s0 + 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
